sequenciador_transmissao_bcd: RTL and testbench
===============================================

Name: sequenciador_transmissao_bcd

Overview:
Controller that sends a multi-digit BCD measurement over the serial link, one ASCII digit at a time, most significant digit first. It sits above the BCD-to-ASCII transmit datapath. It latches the measurement on a start pulse and, for each digit, selects the BCD byte and nibble for the datapath. It then pulses the datapath start, waits for the datapath's done pulse and signals completion or timeout.

Parameters:
NUM_BYTES, 2, number of packed BCD bytes in the measurement (2*NUM_BYTES digits); range 1..8
TIMEOUT_CICLOS, 10000, maximum clocks to wait for pronto_tx per digit before aborting; must be >= 2

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
partida  input  1  one-cycle start request, honoured only in INICIAL
medida  input  8*NUM_BYTES  packed BCD, byte NUM_BYTES-1 most significant, high nibble more significant
pronto_tx  input  1  datapath done, one-cycle pulse at end of each character frame
bcd_sel  output  8  BCD byte presented to datapath
seletor_valor  output  1  1 = high nibble, 0 = low nibble
inicio_tx  output  1  one-cycle start pulse to datapath
ocupado  output  1  high from leaving INICIAL until return to INICIAL
pronto  output  1  one-cycle pulse, measurement fully sent
erro  output  1  one-cycle pulse, timeout abort
db_estado  output  4  current state encoding, debug

Behaviour:
- Reset (reset=0, async): state INICIAL; bcd_sel=0, seletor_valor=0, inicio_tx=0, ocupado=0, pronto=0, erro=0; latched measurement, digit index and timeout counter cleared.
- All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.
- States and encodings: INICIAL=0, PREPARA=1, TRANSMITE=2, ESPERA=3, PROXIMO=4, FINAL=5, ERRO=6. Unused encodings go to INICIAL.
- INICIAL: on partida=1, latch medida and set digit index to 0 (most significant digit). Next state PREPARA. partida in any other state is ignored.
- PREPARA (1 cycle): load bcd_sel = byte (NUM_BYTES-1 - idx/2) and seletor_valor = ~idx[0], so even idx selects the high nibble. Next state TRANSMITE.
- TRANSMITE (1 cycle): inicio_tx=1 and clear the timeout counter. Next state ESPERA.
- ESPERA: pronto_tx is sampled only in this state. On pronto_tx=1, go to PROXIMO. Otherwise the counter increments. When it reaches TIMEOUT_CICLOS-1 without pronto_tx, go to ERRO. If pronto_tx and the last count coincide, pronto_tx wins.
- PROXIMO (1 cycle): if idx = 2*NUM_BYTES-1, go to FINAL; otherwise idx+1 and go to PREPARA.
- FINAL: pronto=1 for 1 cycle, then INICIAL.
- ERRO: erro=1 for 1 cycle, then INICIAL.
- bcd_sel and seletor_valor hold their values from PREPARA until the next PREPARA or reset, so they are stable throughout each frame.
- Per-digit overhead is 3 cycles plus the ESPERA wait. Latency from partida to pronto = 1 + 2*NUM_BYTES*(3 + w) cycles, where w = ESPERA cycles including the pronto_tx cycle.
- Non-decimal nibbles (A–F) are passed through untouched; the datapath's ASCII mapping applies.
- Asserting reset mid-operation aborts immediately with no pronto or erro pulse.

Optional Feature:
SUPRIME_ZEROS_EN
- Defined: leading zero digits are skipped. In PREPARA, a zero nibble before the first nonzero digit routes directly to PROXIMO with no inicio_tx. The least significant digit is always sent, so an all-zero measurement transmits a single "0".
- Undefined: every digit is sent, including leading zeros.

Decomposition:
- Shared package: state encodings, db_estado width, ASCII/BCD constants (4'b0011 prefix).
- One natural sub-module: contador_timeout. Clear/enable inputs, parameter TIMEOUT_CICLOS, "fim" output, width $clog2(TIMEOUT_CICLOS).
- The FSM and digit mux live in the top module.

Test Plan:
- NUM_BYTES=2, medida=16'h1234, partida; datapath model returns pronto_tx 5 cycles after each inicio_tx. Expect 4 inicio_tx pulses with (bcd_sel, seletor_valor) = (12,1), (12,0), (34,1), (34,0); pronto pulses once at cycle 1+4*(3+5)=33; ocupado high throughout.
- medida changes to 16'h9999 mid-transfer; partida pulsed again while busy. Expect the transmitted digits to remain 1,2,3,4 and no restart.
- pronto_tx never returned; TIMEOUT_CICLOS=8. Expect erro pulse after ESPERA has counted 8 cycles, no pronto, then INICIAL with ocupado=0.
- reset driven low during ESPERA of digit 2. Expect all outputs 0 asynchronously, no pronto/erro; a new partida after release restarts from digit 0.
- SUPRIME_ZEROS_EN defined, medida=16'h0042. Expect 2 inicio_tx (4 then 2). medida=16'h0000 yields exactly 1 inicio_tx with low nibble 0.
- pronto_tx pulsed while in INICIAL or PREPARA. Expect it to be ignored, with the digit sequence unchanged.

Source files
------------

// File: rtl/sequenciador_transmissao_bcd_pkg.sv
// rtl/sequenciador_transmissao_bcd_pkg.sv - shared states and BCD/ASCII constants for the BCD transmit sequencer
package sequenciador_transmissao_bcd_pkg;

  localparam int DB_ESTADO_W = 4;

  typedef enum logic [DB_ESTADO_W-1:0] {
    INICIAL   = 4'd0,
    PREPARA   = 4'd1,
    TRANSMITE = 4'd2,
    ESPERA    = 4'd3,
    PROXIMO   = 4'd4,
    FINAL     = 4'd5,
    ERRO      = 4'd6
  } estado_t;

  localparam logic [3:0] ASCII_PREFIXO = 4'b0011;
  localparam logic [3:0] BCD_ZERO      = 4'd0;

  function automatic logic [7:0] bcd_para_ascii(input logic [3:0] digito);
    return {ASCII_PREFIXO, digito};
  endfunction

endpackage

// File: rtl/sequenciador_transmissao_bcd_contador_timeout.sv
// rtl/sequenciador_transmissao_bcd_contador_timeout.sv - per-digit wait counter, fim flags the last allowed cycle
module contador_timeout #(
  parameter int TIMEOUT_CICLOS = 10000
) (
  input  logic clock,
  input  logic reset,
  input  logic limpa,
  input  logic conta,
  output logic fim
);

  localparam int W = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [W-1:0] ULTIMO = W'(TIMEOUT_CICLOS - 1);

  logic [W-1:0] contagem;

  // Saturates at the last count so the flag stays stable if the FSM lingers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      contagem <= '0;
    end else if (limpa) begin
      contagem <= '0;
    end else if (conta && !fim) begin
      contagem <= contagem + 1'b1;
    end
  end

  assign fim = (contagem == ULTIMO);

endmodule

// File: rtl/sequenciador_transmissao_bcd.sv
// rtl/sequenciador_transmissao_bcd.sv - sends a packed BCD measurement digit by digit, MSD first; SUPRIME_ZEROS_EN skips leading zeros
module sequenciador_transmissao_bcd
  import sequenciador_transmissao_bcd_pkg::*;
#(
  parameter int NUM_BYTES      = 2,
  parameter int TIMEOUT_CICLOS = 10000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   partida,
  input  logic [8*NUM_BYTES-1:0] medida,
  input  logic                   pronto_tx,
  output logic [7:0]             bcd_sel,
  output logic                   seletor_valor,
  output logic                   inicio_tx,
  output logic                   ocupado,
  output logic                   pronto,
  output logic                   erro,
  output logic [DB_ESTADO_W-1:0] db_estado
);

  localparam int NUM_DIGITOS = 2 * NUM_BYTES;
  localparam int IDX_W       = $clog2(NUM_DIGITOS);
  localparam logic [IDX_W-1:0] IDX_ULTIMO = IDX_W'(NUM_DIGITOS - 1);
  localparam logic [IDX_W-1:0] BYTE_MSB   = IDX_W'(NUM_BYTES - 1);

  estado_t                estado;
  logic [8*NUM_BYTES-1:0] medida_reg;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       byte_idx;
  logic [7:0]             byte_atual;
  logic                   fim_timeout;

  // Two digits per byte; the most significant byte is sent first.
  assign byte_idx   = BYTE_MSB - (idx >> 1);
  assign byte_atual = medida_reg[8*byte_idx +: 8];
  assign db_estado  = estado;

`ifdef SUPRIME_ZEROS_EN
  logic [3:0] digito_atual;
  logic       achou_nao_zero;
  assign digito_atual = idx[0] ? byte_atual[3:0] : byte_atual[7:4];
`endif

  contador_timeout #(
    .TIMEOUT_CICLOS(TIMEOUT_CICLOS)
  ) u_timeout (
    .clock (clock),
    .reset (reset),
    .limpa (estado == TRANSMITE),
    .conta (estado == ESPERA),
    .fim   (fim_timeout)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado         <= INICIAL;
      medida_reg     <= '0;
      idx            <= '0;
      bcd_sel        <= '0;
      seletor_valor  <= 1'b0;
      inicio_tx      <= 1'b0;
      ocupado        <= 1'b0;
      pronto         <= 1'b0;
      erro           <= 1'b0;
`ifdef SUPRIME_ZEROS_EN
      achou_nao_zero <= 1'b0;
`endif
    end else begin
      inicio_tx <= 1'b0;
      pronto    <= 1'b0;
      erro      <= 1'b0;
      case (estado)
        INICIAL: begin
          if (partida) begin
            medida_reg     <= medida;
            idx            <= '0;
            ocupado        <= 1'b1;
            estado         <= PREPARA;
`ifdef SUPRIME_ZEROS_EN
            achou_nao_zero <= 1'b0;
`endif
          end
        end
        PREPARA: begin
          bcd_sel       <= byte_atual;
          seletor_valor <= ~idx[0];
`ifdef SUPRIME_ZEROS_EN
          // The last digit is always sent so an all-zero value still shows "0".
          if (!achou_nao_zero && digito_atual == BCD_ZERO && idx != IDX_ULTIMO) begin
            estado <= PROXIMO;
          end else begin
            achou_nao_zero <= 1'b1;
            inicio_tx      <= 1'b1;
            estado         <= TRANSMITE;
          end
`else
          inicio_tx <= 1'b1;
          estado    <= TRANSMITE;
`endif
        end
        TRANSMITE: begin
          estado <= ESPERA;
        end
        ESPERA: begin
          if (pronto_tx) begin
            estado <= PROXIMO;
          end else if (fim_timeout) begin
            erro   <= 1'b1;
            estado <= ERRO;
          end
        end
        PROXIMO: begin
          if (idx == IDX_ULTIMO) begin
            pronto <= 1'b1;
            estado <= FINAL;
          end else begin
            idx    <= idx + 1'b1;
            estado <= PREPARA;
          end
        end
        FINAL, ERRO: begin
          ocupado <= 1'b0;
          estado  <= INICIAL;
        end
        default: begin
          ocupado <= 1'b0;
          estado  <= INICIAL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequenciador_transmissao_bcd.sv
// tb/tb_sequenciador_transmissao_bcd.sv - self-checking bench for sequenciador_transmissao_bcd (honours SUPRIME_ZEROS_EN)
module tb_sequenciador_transmissao_bcd;

  localparam int NB = 2;
  localparam int ND = 2 * NB;
  localparam int TO = 8;
`ifdef SUPRIME_ZEROS_EN
  localparam bit SUPR = 1'b1;
`else
  localparam bit SUPR = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic        partida;
  logic [15:0] medida;
  logic        pronto_tx;
  logic        pronto_resp;
  logic        pronto_man;
  logic [7:0]  bcd_sel;
  logic        seletor_valor;
  logic        inicio_tx;
  logic        ocupado;
  logic        pronto;
  logic        erro;
  logic [3:0]  db_estado;

  int          checks = 0;
  int          errors = 0;
  int          atraso = 5;
  logic [8:0]  cap_q[$];

  assign pronto_tx = pronto_resp | pronto_man;

  sequenciador_transmissao_bcd #(
    .NUM_BYTES(NB),
    .TIMEOUT_CICLOS(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .partida(partida),
    .medida(medida),
    .pronto_tx(pronto_tx),
    .bcd_sel(bcd_sel),
    .seletor_valor(seletor_valor),
    .inicio_tx(inicio_tx),
    .ocupado(ocupado),
    .pronto(pronto),
    .erro(erro),
    .db_estado(db_estado)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Datapath stand-in: records each digit request and answers atraso cycles later.
  initial begin
    pronto_resp = 1'b0;
    forever begin
      @(negedge clock);
      if (inicio_tx) begin
        cap_q.push_back({bcd_sel, seletor_valor});
        repeat (atraso) @(negedge clock);
        pronto_resp = 1'b1;
        @(negedge clock);
        pronto_resp = 1'b0;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nome, input int atual, input int esperado);
    checks++;
    if (atual != esperado) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", nome, atual, esperado);
    end
  endtask

  // modo 0: plain run; 1: medida change and partida while busy; 2: stray pronto_tx in INICIAL/PREPARA
  task automatic roda(input string nome, input logic [15:0] med, input int d, input int modo, input int lat_tab);
    logic [8:0] esp_q[$];
    int  n_skip = 0;
    bit  lider  = 1'b1;
    bit  esp_ok;
    int  lat_esp;
    int  lat = -1;
    int  n_pronto = 0;
    int  n_erro = 0;
    int  k = 0;
    bit  ocup_falhou = 1'b0;
    for (int i = 0; i < ND; i++) begin
      int nib;
      int byt;
      nib = (int'(med) >> (4 * (ND - 1 - i))) % 16;
      byt = (int'(med) >> (8 * (NB - 1 - i / 2))) % 256;
      if (SUPR && lider && nib == 0 && i < ND - 1) begin
        n_skip++;
      end else begin
        lider = 1'b0;
        esp_q.push_back({8'(byt), (i % 2 == 0)});
      end
    end
    esp_ok = (d <= TO);
    if (!esp_ok) begin
      while (esp_q.size() > 1) void'(esp_q.pop_back());
    end
    lat_esp = esp_ok ? 1 + 2 * n_skip + esp_q.size() * (3 + d) : 1 + 2 * n_skip + 2 + TO;
    if (lat_tab >= 0) lat_esp = lat_tab;

    @(negedge clock);
    if (modo == 2) begin
      pronto_man = 1'b1;
      @(negedge clock);
      pronto_man = 1'b0;
      @(negedge clock);
    end
    cap_q.delete();
    atraso  = d;
    medida  = med;
    partida = 1'b1;
    while (k < 300 && !(lat >= 0 && k >= lat + 3)) begin
      @(negedge clock);
      k++;
      if (k == 1) partida = 1'b0;
      if (modo == 1 && k == 10) medida = 16'h9999;
      if (modo == 1 && k == 12) partida = 1'b1;
      if (modo == 1 && k == 13) partida = 1'b0;
      if (modo == 2 && k == 1) pronto_man = 1'b1;
      if (modo == 2 && k == 2) pronto_man = 1'b0;
      if (pronto) n_pronto++;
      if (erro) n_erro++;
      if ((pronto || erro) && lat < 0) lat = k;
      if ((lat < 0 || k == lat) && !ocupado) ocup_falhou = 1'b1;
    end
    chk({nome, " latency"}, lat, lat_esp);
    chk({nome, " pronto_count"}, n_pronto, esp_ok ? 1 : 0);
    chk({nome, " erro_count"}, n_erro, esp_ok ? 0 : 1);
    chk({nome, " ocupado_low"}, int'(ocup_falhou), 0);
    chk({nome, " ocupado_after"}, int'(ocupado), 0);
    chk({nome, " digit_count"}, cap_q.size(), esp_q.size());
    for (int i = 0; i < esp_q.size(); i++) begin
      if (i < cap_q.size()) chk({nome, " digit"}, int'(cap_q[i]), int'(esp_q[i]));
    end
  endtask

  typedef struct {
    logic [15:0] med;
    int          d;
    int          modo;
    int          lat;
  } vetor_t;

  vetor_t tab[9];

  initial begin
    int n_evt;
    tab[0] = '{16'h1234, 5, 0, 33};
    tab[1] = '{16'h0000, 1, 0, SUPR ? 11 : 17};
    tab[2] = '{16'hABCD, 8, 0, 45};
    tab[3] = '{16'h0909, 2, 0, SUPR ? 18 : 21};
    tab[4] = '{16'h5678, 9, 0, 11};
    tab[5] = '{16'h0042, 3, 0, SUPR ? 17 : 25};
    tab[6] = '{16'h1234, 5, 1, 33};
    tab[7] = '{16'h1234, 5, 2, 33};
    tab[8] = '{16'h0000, 9, 0, SUPR ? 17 : 11};

    reset      = 1'b0;
    partida    = 1'b0;
    medida     = 16'h0;
    pronto_man = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_outputs", int'({bcd_sel, seletor_valor, inicio_tx, ocupado, pronto, erro, db_estado}), 0);
    reset = 1'b1;
    @(negedge clock);
    chk("idle_state", int'(db_estado), 0);

    for (int i = 0; i < 9; i++) begin
      roda($sformatf("vec%0d", i), tab[i].med, tab[i].d, tab[i].modo, tab[i].lat);
    end

    // Reset during ESPERA of the second digit, then a clean restart.
    @(negedge clock);
    cap_q.delete();
    atraso  = 5;
    medida  = 16'h1234;
    partida = 1'b1;
    @(negedge clock);
    partida = 1'b0;
    repeat (11) @(negedge clock);
    chk("midreset_in_espera", int'(db_estado), 3);
    chk("midreset_bcd_sel_before", int'(bcd_sel), 8'h12);
    reset = 1'b0;
    #1;
    chk("midreset_async_outputs", int'({bcd_sel, seletor_valor, inicio_tx, ocupado, pronto, erro, db_estado}), 0);
    n_evt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (i == 2) reset = 1'b1;
      if (pronto || erro || inicio_tx) n_evt++;
    end
    chk("midreset_no_pulses", n_evt, 0);
    roda("after_reset", 16'h1234, 5, 0, 33);

    for (int i = 0; i < 24; i++) begin
      logic [15:0] m;
      m = 16'($urandom);
      if ($urandom_range(0, 1) == 1) m[15:8] = 8'h00;
      if ($urandom_range(0, 3) == 0) m[7:4] = 4'h0;
      roda($sformatf("rnd%0d", i), m, int'($urandom_range(1, 9)), 0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
